// File: rtl/bounce_pkg.sv
// Shared types for the bounce sequencer and its counter datapath.
// FSM states, datapath commands and default widths live here.
package bounce_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_SWEEP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        INC  = 2'd2,
        DEC  = 2'd3
    } cmd_t;

endpackage

// File: rtl/bounce_dp.sv
// Counter datapath: a WIDTH-bit register stepped by a command.
// Range limiting is the sequencer's job; this block never compares.
module bounce_dp
    import bounce_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  cmd_t             cmd,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            unique case (cmd)
                LOAD:    q <= d;
                INC:     q <= q + WIDTH'(1);
                DEC:     q <= q - WIDTH'(1);
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/bounce_seq_ctrl.sv
// Bounded bounce sequencer: sweeps Lo->Hi->Lo a programmed number of
// times, with endpoint repeat, pause, abort and config-error reporting.
module bounce_seq_ctrl
    import bounce_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SWEEP_W = DEF_SWEEP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [SWEEP_W-1:0] sweeps,
    output logic [WIDTH-1:0]   out,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    state_t               state;
    state_t               state_n;
    cmd_t                 cmd;
    logic [WIDTH-1:0]     lo_l;
    logic [WIDTH-1:0]     hi_l;
    logic [SWEEP_W-1:0]   sweeps_l;
    logic [SWEEP_W-1:0]   cnt;
    logic [SWEEP_W-1:0]   cnt_n;
    logic                 latch;
    logic                 done_n;
    logic                 err_n;

    bounce_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk (clk),
        .rst (rst),
        .cmd (cmd),
        .d   (lo),
        .q   (out)
    );

    // Endpoints are compared before stepping, so the counter cannot wrap.
    always_comb begin
        state_n = state;
        cmd     = HOLD;
        cnt_n   = cnt;
        latch   = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        if (stop) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (lo > hi) begin
                            err_n = 1'b1;
                        end else begin
                            latch   = 1'b1;
                            cmd     = LOAD;
                            cnt_n   = '0;
                            state_n = UP;
                        end
                    end
                end
                UP: begin
                    if (!pause) begin
                        if (out == hi_l) begin
                            state_n = DOWN;
                        end else begin
                            cmd = INC;
                        end
                    end
                end
                DOWN: begin
                    if (!pause) begin
                        if (out == lo_l) begin
                            cnt_n = cnt + SWEEP_W'(1);
                            if (sweeps_l != '0 && cnt_n == sweeps_l) begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end else begin
                                state_n = UP;
                            end
                        end else begin
                            cmd = DEC;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lo_l     <= '0;
            hi_l     <= '0;
            sweeps_l <= '0;
            cnt      <= '0;
            dir      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            dir     <= (state_n == DOWN);
            busy    <= (state_n != IDLE);
            done    <= done_n;
            cfg_err <= err_n;
            if (latch) begin
                lo_l     <= lo;
                hi_l     <= hi;
                sweeps_l <= sweeps;
            end
        end
    end

endmodule

// File: tb/tb_bounce_seq_ctrl.sv
// Directed bench for bounce_seq_ctrl: sweep shapes, limits, pause,
// stop, config error, async reset and back-to-back runs.
module tb_bounce_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] sweeps;
    logic [3:0] out;
    logic       dir;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;

    bounce_seq_ctrl #(
        .WIDTH   (4),
        .SWEEP_W (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .lo      (lo),
        .hi      (hi),
        .sweeps  (sweeps),
        .out     (out),
        .dir     (dir),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] l, input logic [3:0] h,
                          input logic [7:0] s);
        lo = l;
        hi = h;
        sweeps = s;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 0; stop = 0; pause = 0;
        lo = 0; hi = 0; sweeps = 0;
        #3;
        checks++;
        if ({out, dir, busy, done, cfg_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset got out=%0d dir=%b busy=%b done=%b err=%b exp 0",
                     out, dir, busy, done, cfg_err);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || out !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b out=%0d exp 0/0", busy, out);
        end
    endtask

    task automatic test_single_sweep();
        logic [3:0] eo [8];
        logic       ed [8];
        eo = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2};
        ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        launch(4'd2, 4'd5, 8'd1);
        lo = 4'd0;
        hi = 4'd15;
        sweeps = 8'd0;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (out !== eo[c] || dir !== ed[c] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL single c=%0d got out=%0d dir=%b busy=%b done=%b exp out=%0d dir=%b busy=1 done=0",
                         c, out, dir, busy, done, eo[c], ed[c]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out !== 4'd2 || dir !== 1'b0) begin
            errors++;
            $display("FAIL single_done got done=%b busy=%b out=%0d dir=%b exp 1/0/2/0",
                     done, busy, out, dir);
        end
        step();
        checks++;
        if (done !== 1'b0 || out !== 4'd2) begin
            errors++;
            $display("FAIL single_pulse got done=%b out=%0d exp 0/2", done, out);
        end
    endtask

    task automatic test_cfg_err();
        launch(4'd9, 4'd3, 8'd1);
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || out !== 4'd2) begin
            errors++;
            $display("FAIL cfg_err got err=%b busy=%b out=%0d exp 1/0/2",
                     cfg_err, busy, out);
        end
        step();
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b0 || out !== 4'd2) begin
            errors++;
            $display("FAIL cfg_err_pulse got err=%b busy=%b out=%0d exp 0/0/2",
                     cfg_err, busy, out);
        end
    endtask

    task automatic test_full_range();
        int p;
        logic [3:0] exp_o;
        launch(4'd0, 4'd15, 8'd2);
        for (int c = 0; c < 64; c++) begin
            p = c % 32;
            exp_o = (p < 16) ? 4'(p) : 4'(31 - p);
            checks++;
            if (out !== exp_o || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL full c=%0d got out=%0d busy=%b done=%b exp out=%0d busy=1 done=0",
                         c, out, busy, done, exp_o);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out !== 4'd0) begin
            errors++;
            $display("FAIL full_done got done=%b busy=%b out=%0d exp 1/0/0",
                     done, busy, out);
        end
    endtask

    task automatic test_equal_limits();
        launch(4'd7, 4'd7, 8'd3);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (out !== 4'd7 || busy !== 1'b1 || dir !== 1'(c % 2) || done !== 1'b0) begin
                errors++;
                $display("FAIL equal c=%0d got out=%0d busy=%b dir=%b done=%b exp 7/1/%0d/0",
                         c, out, busy, dir, done, c % 2);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out !== 4'd7) begin
            errors++;
            $display("FAIL equal_done got done=%b busy=%b out=%0d exp 1/0/7",
                     done, busy, out);
        end
        step();
    endtask

    task automatic test_pause_stop();
        launch(4'd2, 4'd9, 8'd0);
        step();
        step();
        checks++;
        if (out !== 4'd4) begin
            errors++;
            $display("FAIL pause_pre got out=%0d exp 4", out);
        end
        pause = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (out !== 4'd4 || busy !== 1'b1 || dir !== 1'b0) begin
                errors++;
                $display("FAIL pause c=%0d got out=%0d busy=%b dir=%b exp 4/1/0",
                         c, out, busy, dir);
            end
        end
        pause = 1'b0;
        step();
        step();
        checks++;
        if (out !== 4'd6 || busy !== 1'b1) begin
            errors++;
            $display("FAIL resume got out=%0d busy=%b exp 6/1", out, busy);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (out !== 4'd6 || busy !== 1'b0 || done !== 1'b0 || dir !== 1'b0) begin
            errors++;
            $display("FAIL stop got out=%0d busy=%b done=%b dir=%b exp 6/0/0/0",
                     out, busy, done, dir);
        end
        step();
        checks++;
        if (done !== 1'b0 || out !== 4'd6) begin
            errors++;
            $display("FAIL stop_nodone got done=%b out=%0d exp 0/6", done, out);
        end
    endtask

    task automatic test_endless();
        int dones = 0;
        launch(4'd1, 4'd1, 8'd0);
        for (int c = 0; c < 600; c++) begin
            if (done === 1'b1) dones++;
            step();
        end
        checks++;
        if (dones != 0 || busy !== 1'b1 || out !== 4'd1) begin
            errors++;
            $display("FAIL endless got dones=%0d busy=%b out=%0d exp 0/1/1",
                     dones, busy, out);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL endless_stop got busy=%b done=%b exp 0/0", busy, done);
        end
    endtask

    task automatic test_stop_idle();
        stop = 1'b1;
        launch(4'd3, 4'd4, 8'd1);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || out !== 4'd1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle got busy=%b out=%0d err=%b exp 0/1/0",
                     busy, out, cfg_err);
        end
    endtask

    task automatic test_reset_mid();
        launch(4'd2, 4'd5, 8'd1);
        for (int c = 0; c < 5; c++) step();
        checks++;
        if (out !== 4'd4 || dir !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got out=%0d dir=%b exp 4/1", out, dir);
        end
        lo = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (out !== 4'd3 || busy !== 1'b1 || dir !== 1'b1) begin
            errors++;
            $display("FAIL busy_start got out=%0d busy=%b dir=%b exp 3/1/1",
                     out, busy, dir);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 4'd0 || busy !== 1'b0 || dir !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_rst got out=%0d busy=%b dir=%b done=%b exp 0/0/0/0",
                     out, busy, dir, done);
        end
        #1;
        rst = 1'b0;
        step();
        checks++;
        if (out !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_rst got out=%0d busy=%b done=%b exp 0/0/0",
                     out, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        launch(4'd4, 4'd5, 8'd1);
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (done !== 1'b1 || out !== 4'd4) begin
            errors++;
            $display("FAIL b2b_first got done=%b out=%0d exp 1/4", done, out);
        end
        launch(4'd1, 4'd1, 8'd1);
        checks++;
        if (out !== 4'd1 || busy !== 1'b1 || done !== 1'b0 || dir !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept got out=%0d busy=%b done=%b dir=%b exp 1/1/0/0",
                     out, busy, done, dir);
        end
        step();
        checks++;
        if (out !== 4'd1 || dir !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_turn got out=%0d dir=%b busy=%b exp 1/1/1",
                     out, dir, busy);
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done got done=%b busy=%b exp 1/0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_cfg_err();
        test_full_range();
        test_equal_limits();
        test_pause_stop();
        test_endless();
        test_stop_idle();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
